// File: rtl/ledshare_rrpick.sv
// Round-robin pick for the LED share arbiter: finds the first requester after
// the previous owner, wrapping round so the previous owner is considered last.
module ledshare_rrpick #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic            o_any,
    output logic [IW-1:0]   o_pick
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        o_any  = |i_req;
        o_pick = i_last;
        idx    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = IW'((int'(i_last) + off) % NREQ);
            if (i_req[idx]) begin
                o_pick = idx;
            end
        end
    end

endmodule

// File: rtl/ledshare_arbiter.sv
// Shares one LED bank between NREQ pattern sources using round-robin grants,
// a lease timer against monopolisation and a blank gap at every handover.
module ledshare_arbiter #(
    parameter int                   NLEDS     = 8,
    parameter int                   NREQ      = 3,
    parameter int                   LEASEBITS = 24,
    parameter logic [LEASEBITS-1:0] LEASE     = 24'd10_000_000,
    parameter int                   GAPCYC    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*NLEDS-1:0] i_leds,
    output logic [NREQ-1:0]       o_grant,
    output logic [NLEDS-1:0]      o_led,
    output logic                  o_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [IW-1:0]        last;
    logic [LEASEBITS-1:0] lease_ctr;
    logic [7:0]           gap_ctr;
    logic                 any_req;
    logic [IW-1:0]        pick;
    logic [NREQ-1:0]      owner_mask;
    logic                 contended;
    logic                 leave;
    logic                 gap_done;
    logic                 take_grant;
    logic [NLEDS-1:0]     pat [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_pat
        assign pat[k] = i_leds[k*NLEDS +: NLEDS];
    end

    ledshare_rrpick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req  (i_req),
        .i_last (last),
        .o_any  (any_req),
        .o_pick (pick)
    );

    // Release (owner drops) and revoke (lease spent while others wait) both leave OWN.
    assign owner_mask = NREQ'(1) << last;
    assign contended  = |(i_req & ~owner_mask);
    assign leave      = (state == S_OWN) &&
                        (!i_req[last] || (contended && lease_ctr >= LEASE - LEASEBITS'(1)));
    assign gap_done   = (gap_ctr == 8'(GAPCYC - 1));
    assign take_grant = any_req && ((state == S_IDLE) || (state == S_GAP && gap_done));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (any_req) next_state = S_OWN;
            S_OWN:   if (leave) next_state = S_GAP;
            S_GAP:   if (gap_done) next_state = any_req ? S_OWN : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_grant   <= '0;
            o_led     <= '0;
            last      <= IW'(NREQ - 1);
            lease_ctr <= '0;
            gap_ctr   <= '0;
        end else begin
            if (take_grant) begin
                o_grant   <= NREQ'(1) << pick;
                o_led     <= '0;
                last      <= pick;
                lease_ctr <= '0;
            end else if (state == S_OWN && !leave) begin
                o_led <= pat[last];
                if (lease_ctr != LEASE) begin
                    lease_ctr <= lease_ctr + LEASEBITS'(1);
                end
            end else begin
                o_grant <= '0;
                o_led   <= '0;
            end

            if (leave) begin
                gap_ctr <= '0;
            end else if (state == S_GAP) begin
                gap_ctr <= gap_ctr + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ledshare_arbiter.sv
// Directed bench for ledshare_arbiter with LEASE=8, GAPCYC=4, NREQ=3.
module tb_ledshare_arbiter;

    typedef struct {
        logic [2:0] req;
        logic       rst_n;
        logic [2:0] grant;
        logic [7:0] led;
        logic       busy;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [2:0]  i_req = '0;
    logic [23:0] i_leds = {8'h3C, 8'h5A, 8'hA5};
    logic [2:0]  o_grant;
    logic [7:0]  o_led;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    logic [7:0] pats [3];

    ledshare_arbiter #(
        .NLEDS     (8),
        .NREQ      (3),
        .LEASEBITS (24),
        .LEASE     (24'd8),
        .GAPCYC    (4)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     (i_req),
        .i_leds    (i_leds),
        .o_grant   (o_grant),
        .o_led     (o_led),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic applyStimulus(input logic [2:0] req, input logic rst_n);
        @(negedge i_clk);
        i_req     = req;
        i_reset_n = rst_n;
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] g,
                               input logic [7:0] l, input logic b);
        checks++;
        if (o_grant !== g || o_led !== l || o_busy !== b) begin
            errors++;
            $display("[TB] FAIL %s: grant=%b led=%h busy=%b, expected grant=%b led=%h busy=%b",
                     name, o_grant, o_led, o_busy, g, l, b);
        end
    endtask

    task automatic addVec(input logic [2:0] req, input logic rst_n, input int n,
                          input logic [2:0] g, input logic [7:0] l, input logic b);
        vec_t v;
        v.req = req; v.rst_n = rst_n; v.grant = g; v.led = l; v.busy = b;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        pats[0] = 8'hA5;
        pats[1] = 8'h5A;
        pats[2] = 8'h3C;

        // First grant, contended lease expiry, release with rotation, return to idle.
        addVec(3'b000, 1'b0, 1, 3'b000, 8'h00, 1'b0);
        addVec(3'b000, 1'b1, 1, 3'b000, 8'h00, 1'b0);
        addVec(3'b001, 1'b1, 1, 3'b001, 8'h00, 1'b1);
        addVec(3'b001, 1'b1, 1, 3'b001, 8'hA5, 1'b1);
        addVec(3'b011, 1'b1, 6, 3'b001, 8'hA5, 1'b1);
        addVec(3'b011, 1'b1, 4, 3'b000, 8'h00, 1'b1);
        addVec(3'b011, 1'b1, 1, 3'b010, 8'h00, 1'b1);
        addVec(3'b011, 1'b1, 2, 3'b010, 8'h5A, 1'b1);
        addVec(3'b101, 1'b1, 4, 3'b000, 8'h00, 1'b1);
        addVec(3'b101, 1'b1, 1, 3'b100, 8'h00, 1'b1);
        addVec(3'b101, 1'b1, 1, 3'b100, 8'h3C, 1'b1);
        addVec(3'b000, 1'b1, 4, 3'b000, 8'h00, 1'b1);
        addVec(3'b000, 1'b1, 1, 3'b000, 8'h00, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].rst_n);
            checkOutput($sformatf("table[%0d]", i), vecs[i].grant, vecs[i].led, vecs[i].busy);
        end

        // All three requesting: 8-cycle grants rotating 0,1,2 with 4-cycle gaps.
        applyStimulus(3'b000, 1'b0);
        checkOutput("rr_reset", 3'b000, 8'h00, 1'b0);
        for (int c = 0; c < 60; c++) begin
            int phase;
            int owner;
            logic [2:0] eg;
            logic [7:0] el;
            phase = c % 12;
            owner = (c / 12) % 3;
            eg = (phase < 8) ? 3'(1 << owner) : 3'b000;
            el = (phase >= 1 && phase < 8) ? pats[owner] : 8'h00;
            applyStimulus(3'b111, 1'b1);
            checkOutput($sformatf("rr_cycle%0d", c), eg, el, 1'b1);
            checks++;
            if ($countones(o_grant) > 1) begin
                errors++;
                $display("[TB] FAIL onehot_cycle%0d: grant=%b, expected at most one bit set", c, o_grant);
            end
        end

        // Uncontended hold past the lease, then a late competitor forces a revoke.
        applyStimulus(3'b000, 1'b0);
        for (int c = 0; c < 40; c++) begin
            applyStimulus(3'b001, 1'b1);
            if (c == 0) checkOutput("hold_first", 3'b001, 8'h00, 1'b1);
            else if (c == 39) checkOutput("hold_last", 3'b001, 8'hA5, 1'b1);
        end
        checks++;
        if (dut.lease_ctr !== 24'd8) begin
            errors++;
            $display("[TB] FAIL lease_sat: lease_ctr=%0d, expected 8", dut.lease_ctr);
        end
        applyStimulus(3'b101, 1'b1);
        checkOutput("late_revoke", 3'b000, 8'h00, 1'b1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(3'b101, 1'b1);
            checkOutput($sformatf("late_gap%0d", c), 3'b000, 8'h00, 1'b1);
        end
        applyStimulus(3'b101, 1'b1);
        checkOutput("late_grant2", 3'b100, 8'h00, 1'b1);
        applyStimulus(3'b101, 1'b1);
        checkOutput("late_led2", 3'b100, 8'h3C, 1'b1);

        // Hand over to requester 1, then reset mid-lease: last must return to NREQ-1.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(3'b010, 1'b1);
            checkOutput($sformatf("handover_gap%0d", c), 3'b000, 8'h00, 1'b1);
        end
        applyStimulus(3'b010, 1'b1);
        checkOutput("handover_grant1", 3'b010, 8'h00, 1'b1);
        applyStimulus(3'b110, 1'b1);
        checkOutput("handover_led1", 3'b010, 8'h5A, 1'b1);
        applyStimulus(3'b110, 1'b0);
        checkOutput("reset_midlease", 3'b000, 8'h00, 1'b0);
        applyStimulus(3'b110, 1'b1);
        checkOutput("after_lease_reset", 3'b010, 8'h00, 1'b1);

        // Owner 1 drops, reset lands inside the gap.
        applyStimulus(3'b100, 1'b1);
        checkOutput("gap_enter", 3'b000, 8'h00, 1'b1);
        applyStimulus(3'b100, 1'b1);
        checkOutput("gap_mid", 3'b000, 8'h00, 1'b1);
        applyStimulus(3'b110, 1'b0);
        checkOutput("reset_midgap", 3'b000, 8'h00, 1'b0);
        applyStimulus(3'b110, 1'b1);
        checkOutput("after_gap_reset", 3'b010, 8'h00, 1'b1);
        applyStimulus(3'b110, 1'b1);
        checkOutput("after_gap_led", 3'b010, 8'h5A, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
